// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
//   Shared types and helpers for the program-counter sequencer.
//   - next_sel_e  : which source feeds the next PC
//   - sext_shift  : sign-extends a branch offset and converts words to bytes
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_RET
    } next_sel_e;

    // Sign-extends the low off_w bits of offset to 64 bits, then shifts left.
    // Callers truncate the result to their address width; wrap-around is intended.
    function automatic logic [63:0] sext_shift(input logic [63:0] offset,
                                               input int unsigned off_w,
                                               input int unsigned shift);
        logic signed [63:0] v;
        v = $signed(offset << (64 - off_w));
        v = v >>> (64 - off_w);
        return v << shift;
    endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// return_addr_stack
//   Circular LIFO of return addresses with sticky overflow/underflow flags.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     push_i         : write push_data_i above the current top
//     pop_i          : discard the current top (push_i and pop_i are never both high)
//     push_data_i    : address to store on push
//     top_data_o     : entry at the top pointer
//     empty_o/full_o : count == 0 / count == DEPTH
//     overflow_o     : sticky, push seen while full
//     underflow_o    : sticky, pop seen while empty
module return_addr_stack #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_data_i,
    output logic [ADDR_W-1:0] top_data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    assign empty_o     = (cnt_q == '0);
    assign full_o      = (cnt_q == CNT_W'(DEPTH));
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign top_data_o  = mem_q[ptr_q];

    // Pointer wraps naturally at DEPTH (power of two), so a push while full
    // lands on the oldest entry.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push_i) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (full_o) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i) begin
            if (empty_o) begin
                unf_d = 1'b1;
            end else begin
                ptr_d = ptr_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[ptr_q + PTR_W'(1)] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Registered program counter with prioritised next-address selection
//   (stall > ret > call/jump > branch > sequential) and a return-address stack.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     stall                : hold PC and RAS
//     branch_taken         : PC-relative branch by branch_offset words (signed)
//     jump / call          : absolute target jump_index words (call also pushes pc+INC)
//     ret                  : jump to popped RAS top (pc+INC if RAS empty)
//     pc                   : registered PC
//     pc_next              : combinational next PC
//     ras_empty/ras_full   : RAS occupancy
//     ras_overflow/underflow : sticky RAS error flags
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       OFF_W     = 16,
    parameter int unsigned       SHIFT     = 2,
    parameter int unsigned       INC       = 4,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [OFF_W-1:0]  branch_offset,
    input  logic              jump,
    input  logic              call,
    input  logic [OFF_W-1:0]  jump_index,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] seq, br, jt, ras_top;
    logic              push, pop;
    next_sel_e         sel;

    assign seq = pc_q + ADDR_W'(INC);
    assign br  = pc_q + ADDR_W'(sext_shift(64'(branch_offset), OFF_W, SHIFT));
    assign jt  = ADDR_W'(jump_index) << SHIFT;

    always_comb begin
        sel = SEL_SEQ;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (ret) begin
            sel = SEL_RET;
        end else if (call || jump) begin
            sel = SEL_JMP;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        pc_d = seq;
        unique case (sel)
            SEL_HOLD: pc_d = pc_q;
            SEL_RET:  pc_d = ras_empty ? seq : ras_top;
            SEL_JMP:  pc_d = jt;
            SEL_BR:   pc_d = br;
            default:  pc_d = seq;
        endcase
    end

    // Pre-empted requests leave no trace: push only when call actually wins.
    assign push = (sel == SEL_JMP) && call;
    assign pop  = (sel == SEL_RET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc      = pc_q;
    assign pc_next = pc_d;

    return_addr_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (seq),
        .top_data_o  (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full),
        .overflow_o  (ras_overflow),
        .underflow_o (ras_underflow)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, jump, call, ret;
    logic [15:0] branch_offset, jump_index;
    logic [31:0] pc, pc_next;
    logic        ras_empty, ras_full, ras_overflow, ras_underflow;

    int total = 0;
    int bad   = 0;

    // Reference model: PC value, return stack as a queue (back = newest), flags.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_ovf, m_unf;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W    (32),
        .OFF_W     (16),
        .SHIFT     (2),
        .INC       (4),
        .RAS_DEPTH (4),
        .RESET_VEC (32'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .call          (call),
        .jump_index    (jump_index),
        .ret           (ret),
        .pc            (pc),
        .pc_next       (pc_next),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next();
        logic        [31:0] seq, br, jt;
        logic signed [31:0] off;
        off = $signed(branch_offset);
        seq = m_pc + 32'd4;
        br  = m_pc + off * 4;
        jt  = {16'h0, jump_index} * 4;
        if (stall)                 return m_pc;
        if (ret)                   return (m_ras.size() > 0) ? m_ras[$] : seq;
        if (call || jump)          return jt;
        if (branch_taken)          return br;
        return seq;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":pc"},        pc,                      m_pc);
        chk({tag, ":empty"},     {31'b0, ras_empty},      {31'b0, m_ras.size() == 0});
        chk({tag, ":full"},      {31'b0, ras_full},       {31'b0, m_ras.size() == 4});
        chk({tag, ":overflow"},  {31'b0, ras_overflow},   {31'b0, m_ovf});
        chk({tag, ":underflow"}, {31'b0, ras_underflow},  {31'b0, m_unf});
    endtask

    // Called at a falling edge: apply inputs, check pc_next, clock once, check state.
    task automatic step(input string tag, input logic s, input logic r, input logic c,
                        input logic j, input logic b, input logic [15:0] off,
                        input logic [15:0] idx);
        logic [31:0] nxt;
        stall = s; ret = r; call = c; jump = j; branch_taken = b;
        branch_offset = off; jump_index = idx;
        #1;
        nxt = model_next();
        chk({tag, ":pc_next"}, pc_next, nxt);
        @(posedge clk);
        if (!stall) begin
            if (ret) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
                else m_unf = 1'b1;
            end else if (call) begin
                if (m_ras.size() == 4) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_ras.push_back(m_pc + 32'd4);
            end
        end
        m_pc = nxt;
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; ret = 1'b0; call = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        branch_offset = 16'h0; jump_index = 16'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_state("reset");
        rst_n = 1'b1;

        // Free-running after reset
        idle("run1"); chk("run1:const", pc, 32'h4);
        idle("run2"); chk("run2:const", pc, 32'h8);
        idle("run3"); chk("run3:const", pc, 32'hC);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_state("async_rst");
        chk("async_rst:const", pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // PC-relative branches
        step("j100", 0, 0, 0, 1, 0, 16'h0, 16'h0040);
        step("br_neg", 0, 0, 0, 0, 1, 16'hFFFE, 16'h0);
        chk("br_neg:const", pc, 32'hF8);
        step("j100b", 0, 0, 0, 1, 0, 16'h0, 16'h0040);
        step("br_pos", 0, 0, 0, 0, 1, 16'h0003, 16'h0);
        chk("br_pos:const", pc, 32'h10C);

        // Wrap-around and absolute jump
        step("j0", 0, 0, 0, 1, 0, 16'h0, 16'h0);
        step("br_m1", 0, 0, 0, 0, 1, 16'hFFFF, 16'h0);
        chk("br_m1:const", pc, 32'hFFFF_FFFC);
        idle("wrap");
        chk("wrap:const", pc, 32'h0);
        step("jmp", 0, 0, 0, 1, 0, 16'h0, 16'h1234);
        chk("jmp:const", pc, 32'h48D0);

        // Call / return
        step("j40", 0, 0, 0, 1, 0, 16'h0, 16'h0010);
        step("call", 0, 0, 1, 0, 0, 16'h0, 16'h0100);
        chk("call:const", pc, 32'h400);
        idle("body");
        step("ret", 0, 1, 0, 0, 0, 16'h0, 16'h0);
        chk("ret:const", pc, 32'h44);
        chk("ret:empty_const", {31'b0, ras_empty}, 32'h1);

        // Nested calls beyond depth, then unwind past empty
        for (int i = 1; i <= 5; i++) step("ncall", 0, 0, 1, 0, 0, 16'h0, 16'(i * 16));
        chk("ncall:ovf_const", {31'b0, ras_overflow}, 32'h1);
        chk("ncall:full_const", {31'b0, ras_full}, 32'h1);
        for (int i = 1; i <= 5; i++) step("nret", 0, 1, 0, 0, 0, 16'h0, 16'h0);
        chk("nret:unf_const", {31'b0, ras_underflow}, 32'h1);

        // Stall with pending requests, then combined ret/call/branch
        rst_n = 1'b0;
        #1 model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("pre", 0, 0, 1, 0, 0, 16'h0, 16'h0200);
        step("stall", 1, 0, 1, 0, 1, 16'h0010, 16'h0300);
        step("stall_ret", 1, 1, 0, 0, 0, 16'h0, 16'h0);
        step("combo", 0, 1, 1, 0, 1, 16'h0010, 16'h0300);
        chk("combo:const", pc, 32'h4);
        chk("combo:empty_const", {31'b0, ras_empty}, 32'h1);
        chk("combo:ovf_const", {31'b0, ras_overflow}, 32'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            step("rand",
                 ($urandom_range(7) == 0), ($urandom_range(4) == 0),
                 ($urandom_range(3) == 0), ($urandom_range(6) == 0),
                 ($urandom_range(3) == 0),
                 16'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parameterised, registered program-counter unit for the single-cycle CPU. It holds the architectural PC and each cycle selects one next address:
- sequential increment
- PC-relative branch
- absolute jump
- call (jump plus return-address push)
- return (pop)

A small internal return-address stack (RAS) provides call/return. The unit feeds instruction-memory address generation and drives the fetch stage directly.

Parameters:
ADDR_W, 32, width of the PC and of all address arithmetic.
OFF_W, 16, width of the signed branch offset and the unsigned jump index.
SHIFT, 2, left shift applied to the offset and the index (word to byte).
INC, 4, sequential increment in bytes.
RAS_DEPTH, 4, return-stack entries; power of two, at least 2.
RESET_VEC, 0, PC value loaded on reset.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hold the PC and the RAS; no push or pop.
branch_taken  in  1  take the PC-relative branch.
branch_offset  in  OFF_W  signed word offset.
jump  in  1  absolute jump.
call  in  1  absolute jump plus push of pc+INC.
jump_index  in  OFF_W  target index for jump/call.
ret  in  1  pop the RAS and jump to the popped address.
pc  out  ADDR_W  current registered PC.
pc_next  out  ADDR_W  combinational next PC; equals pc while stalled.
ras_empty  out  1  RAS count == 0.
ras_full  out  1  RAS count == RAS_DEPTH.
ras_overflow  out  1  sticky: a push occurred while full.
ras_underflow  out  1  sticky: a pop occurred while empty.

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc = RESET_VEC
  - RAS count = 0, top pointer = 0
  - both sticky flags = 0
  - RAS entry contents are don't-care
  - Reset is effective immediately, mid-operation included. The first update happens on the first rising clk edge after rst_n goes high.
- Arithmetic is modulo 2^ADDR_W; carry is discarded, so wrap-around is legal.
  - seq = pc + INC
  - br = pc + (sign_extend(branch_offset) << SHIFT)
  - jt = zero_extend(jump_index) << SHIFT
- Next-PC priority, highest first:
  - stall → pc
  - ret → RAS top, or seq if the RAS is empty
  - call → jt
  - jump → jt
  - branch_taken → br
  - otherwise → seq
- pc_next is combinational from the current inputs. pc <= pc_next on every rising edge, so there is one cycle of latency from a request to the pc update.
- Lower-priority requests asserted in the same cycle are ignored entirely, with no side effects. Example: call with ret pops only and does not push.
- RAS is a circular LIFO.
  - Push (call, not stalled, not pre-empted by ret): write seq at top+1, increment the pointer, count = min(count+1, RAS_DEPTH).
  - Push while full overwrites the oldest entry and sets ras_overflow.
  - Pop (ret, not stalled): read the top entry, decrement the pointer and count.
  - Pop while empty: pointer and count unchanged, target = seq, sets ras_underflow.
- Sticky flags clear only on reset.

Decomposition:
- Package pc_sequencer_pkg holds:
  - the next-PC source select enum: SEL_HOLD, SEL_SEQ, SEL_BR, SEL_JMP, SEL_RET
  - function sext_shift(offset) for the branch-offset sign extension and shift
- One sub-module, return_addr_stack, contains:
  - the RAS storage and pointer/count logic
  - full/empty/overflow/underflow flags
  - push and pop inputs and the top_data output
- The top level contains the priority select, the address adders and the pc register.

Test Plan:
- Reset then 3 free-running cycles → pc = 0, then 4, 8, 0xC. Assert rst_n low mid-run → pc = 0 asynchronously, before the next edge.
- pc = 0x100, branch_offset = 0xFFFE (−2), branch_taken → pc = 0xF8 next cycle. Offset 0x0003 → 0x10C.
- pc = 0xFFFFFFFC, no request → pc = 0x00000000 (wrap). jump with jump_index = 0x1234 → pc = 0x48D0.
- From pc = 0x40: call index 0x100 → pc = 0x400, RAS holds 0x44. Later ret → pc = 0x44, ras_empty = 1.
- Five nested calls (RAS_DEPTH = 4) → ras_overflow = 1, ras_full = 1. Five rets return the four newest addresses; the fifth returns seq and sets ras_underflow.
- stall with branch_taken and call → pc, RAS count and flags unchanged. ret + call + branch in the same cycle → only the pop is taken.
